// File: rtl/snake_pkg.sv
// Shared types and default speed constants for the snake core.
package snake_pkg;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    RUN   = 2'd1,
    PAUSE = 2'd2,
    OVER  = 2'd3
  } tick_state_t;

  localparam int unsigned DefDwidth      = 8;
  localparam int unsigned DefLevels      = 8;
  localparam int unsigned DefBasePeriod  = 30;
  localparam int unsigned DefStepPeriod  = 3;
  localparam int unsigned DefMinPeriod   = 6;

endpackage

// File: rtl/speed_period.sv
// Combinational speed level to tick period map, floored at MIN_PERIOD without underflow.
module speed_period
  import snake_pkg::*;
#(
  parameter int unsigned dwidth      = DefDwidth,
  parameter int unsigned LW          = $clog2(DefLevels),
  parameter int unsigned BASE_PERIOD = DefBasePeriod,
  parameter int unsigned STEP_PERIOD = DefStepPeriod,
  parameter int unsigned MIN_PERIOD  = DefMinPeriod
) (
  input  logic [LW-1:0]     level_i,
  output logic [dwidth-1:0] period_o
);

  localparam logic [31:0] Span = 32'(BASE_PERIOD - MIN_PERIOD);

  logic [31:0] reduction;

  always_comb begin
    reduction = 32'(level_i) * STEP_PERIOD;
    // Compare against the span first so the subtraction can never wrap.
    if (reduction >= Span) begin
      period_o = dwidth'(MIN_PERIOD);
    end else begin
      period_o = dwidth'(32'(BASE_PERIOD) - reduction);
    end
  end

endmodule

// File: rtl/tick_scheduler.sv
// Game-speed controller: counts frame strobes into game ticks and sequences run/pause/over.
module tick_scheduler
  import snake_pkg::*;
#(
  parameter int unsigned dwidth      = DefDwidth,
  parameter int unsigned LEVELS      = DefLevels,
  parameter int unsigned BASE_PERIOD = DefBasePeriod,
  parameter int unsigned STEP_PERIOD = DefStepPeriod,
  parameter int unsigned MIN_PERIOD  = DefMinPeriod,
  localparam int unsigned LW         = $clog2(LEVELS)
) (
  input  logic          clk,
  input  logic          reset,
  input  logic          frame_en,
  input  logic          start,
  input  logic          pause,
  input  logic          speed_up,
  input  logic          game_over,
  output logic          tick,
  output logic [LW-1:0] level,
  output logic [1:0]    state,
  output logic          running
);

  localparam logic [LW-1:0] MaxLevel = LW'(LEVELS - 1);

  tick_state_t       state_q, state_d;
  logic [dwidth-1:0] count_q, count_d;
  logic [LW-1:0]     level_q, level_d;
  logic              tick_q, tick_d;
  logic [dwidth-1:0] period;

  speed_period #(
    .dwidth      (dwidth),
    .LW          (LW),
    .BASE_PERIOD (BASE_PERIOD),
    .STEP_PERIOD (STEP_PERIOD),
    .MIN_PERIOD  (MIN_PERIOD)
  ) u_speed_period (
    .level_i  (level_q),
    .period_o (period)
  );

  always_comb begin
    state_d = state_q;
    count_d = count_q;
    level_d = level_q;
    tick_d  = 1'b0;
    unique case (state_q)
      IDLE, OVER: begin
        if (start) begin
          state_d = RUN;
          count_d = '0;
          level_d = '0;
        end
      end
      RUN: begin
        if (game_over) begin
          state_d = OVER;
        end else if (pause) begin
          state_d = PAUSE;
        end else begin
          // >= catches a count left above a period that just shrank.
          if (frame_en) begin
            if (count_q >= period - dwidth'(1)) begin
              count_d = '0;
              tick_d  = 1'b1;
            end else begin
              count_d = count_q + dwidth'(1);
            end
          end
          if (speed_up && (level_q != MaxLevel)) begin
            level_d = level_q + LW'(1);
          end
        end
      end
      PAUSE: begin
        if (game_over) begin
          state_d = OVER;
        end else if (pause) begin
          state_d = RUN;
        end
      end
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q <= IDLE;
      count_q <= '0;
      level_q <= '0;
      tick_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      count_q <= count_d;
      level_q <= level_d;
      tick_q  <= tick_d;
    end
  end

  assign tick    = tick_q;
  assign level   = level_q;
  assign state   = state_q;
  assign running = (state_q == RUN);

endmodule

// File: tb/tb_tick_scheduler.sv
// Self-checking bench for tick_scheduler: vector table, random run vs. model, async reset.
module tb_tick_scheduler;

  logic       clk = 1'b0;
  logic       reset = 1'b1;
  logic       frame_en = 1'b0, start = 1'b0, pause = 1'b0, speed_up = 1'b0, game_over = 1'b0;
  logic       tick;
  logic [1:0] level;
  logic [1:0] state;
  logic       running;

  int tests = 0;
  int fails = 0;

  tick_scheduler #(
    .dwidth      (8),
    .LEVELS      (4),
    .BASE_PERIOD (4),
    .STEP_PERIOD (1),
    .MIN_PERIOD  (2)
  ) dut (
    .clk       (clk),
    .reset     (reset),
    .frame_en  (frame_en),
    .start     (start),
    .pause     (pause),
    .speed_up  (speed_up),
    .game_over (game_over),
    .tick      (tick),
    .level     (level),
    .state     (state),
    .running   (running)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic fe, st, pa, su, go;
    logic et;
    int   el;
    int   es;
  } vec_t;

  vec_t tbl[$];

  // Reference model: state 0..3, strobes since last tick, speed level.
  int m_st, m_cnt, m_lvl, m_tick;

  function automatic int mperiod(input int l);
    int p;
    p = 4 - l * 1;
    return (p < 2) ? 2 : p;
  endfunction

  task automatic model_reset();
    m_st = 0; m_cnt = 0; m_lvl = 0; m_tick = 0;
  endtask

  task automatic model_step(input logic fe, st, pa, su, go);
    m_tick = 0;
    if (m_st == 0 || m_st == 3) begin
      if (st) begin m_st = 1; m_cnt = 0; m_lvl = 0; end
    end else if (m_st == 1) begin
      if (go) m_st = 3;
      else if (pa) m_st = 2;
      else begin
        if (fe) begin
          m_cnt = m_cnt + 1;
          if (m_cnt >= mperiod(m_lvl)) begin m_cnt = 0; m_tick = 1; end
        end
        if (su && m_lvl < 3) m_lvl = m_lvl + 1;
      end
    end else begin
      if (go) m_st = 3;
      else if (pa) m_st = 1;
    end
  endtask

  task automatic add(input logic fe, st, pa, su, go, et, input int el, es);
    vec_t v;
    v.fe = fe; v.st = st; v.pa = pa; v.su = su; v.go = go;
    v.et = et; v.el = el; v.es = es;
    tbl.push_back(v);
  endtask

  task automatic chk(input string name, input int act, input int exp);
    tests++;
    if (act != exp) begin
      fails++;
      $display("FAIL %s: got %0d expected %0d at t=%0t", name, act, exp, $time);
    end
  endtask

  task automatic check_all(input string name, input int et, el, es);
    chk({name, ".tick"}, int'(tick), et);
    chk({name, ".level"}, int'(level), el);
    chk({name, ".state"}, int'(state), es);
    chk({name, ".running"}, int'(running), (es == 1) ? 1 : 0);
  endtask

  // Inputs applied just after an edge, held for one cycle, outputs then read 1 time unit past it.
  task automatic drive(input logic fe, st, pa, su, go);
    frame_en = fe; start = st; pause = pa; speed_up = su; game_over = go;
    @(posedge clk);
    #1;
    frame_en = 0; start = 0; pause = 0; speed_up = 0; game_over = 0;
  endtask

  initial begin
    // Basic ticking from start: ticks after strobes 4, 8, 12.
    add(0,1,0,0,0, 0,0,1);
    for (int i = 1; i <= 12; i++) add(1,0,0,0,0, (i % 4 == 0), 0, 1);
    // Speed saturation, then ticks every 2 strobes.
    for (int i = 0; i < 5; i++) add(0,0,0,1,0, 0, (i < 3) ? i + 1 : 3, 1);
    for (int i = 1; i <= 4; i++) add(1,0,0,0,0, (i % 2 == 0), 3, 1);
    // Pause holds everything, ignores start and speed_up.
    add(0,0,1,0,0, 0,3,2);
    add(1,0,0,0,0, 0,3,2);
    add(0,1,0,0,0, 0,3,2);
    add(0,0,0,1,0, 0,3,2);
    add(0,0,1,0,0, 0,3,1);
    for (int i = 1; i <= 4; i++) add(1,0,0,0,0, (i % 2 == 0), 3, 1);
    // game_over + pause on a terminal strobe: OVER, no tick, level held.
    add(1,0,0,0,0, 0,3,1);
    add(1,0,1,0,1, 0,3,3);
    add(1,0,0,0,0, 0,3,3);
    add(0,0,1,0,0, 0,3,3);
    add(0,0,0,1,0, 0,3,3);
    add(0,1,0,0,0, 0,0,1);
    // Period shrinks below count: next strobe still wraps.
    for (int i = 0; i < 3; i++) add(1,0,0,0,0, 0,0,1);
    for (int i = 1; i <= 3; i++) add(0,0,0,1,0, 0,i,1);
    add(1,0,0,0,0, 1,3,1);
    add(1,0,0,0,0, 0,3,1);
    add(1,0,0,0,0, 1,3,1);
    // speed_up with a counted strobe uses the old period.
    add(0,0,0,0,1, 0,3,3);
    add(0,1,0,0,0, 0,0,1);
    for (int i = 0; i < 3; i++) add(1,0,0,0,0, 0,0,1);
    add(1,0,0,1,0, 1,1,1);
    add(1,0,0,1,0, 0,2,1);
    add(1,0,0,0,0, 1,2,1);
    // Pause after 2 strobes, 10 strobes paused, 2 more to tick.
    add(0,0,0,0,1, 0,2,3);
    add(0,1,0,0,0, 0,0,1);
    add(1,0,0,0,0, 0,0,1);
    add(1,0,0,0,0, 0,0,1);
    add(0,0,1,0,0, 0,0,2);
    for (int i = 0; i < 10; i++) add(1,0,0,0,0, 0,0,2);
    add(0,0,1,0,0, 0,0,1);
    add(1,0,0,0,0, 0,0,1);
    add(1,0,0,0,0, 1,0,1);

    // Reset state.
    repeat (2) @(posedge clk);
    #1;
    check_all("reset", 0, 0, 0);
    reset = 0;

    foreach (tbl[i]) begin
      drive(tbl[i].fe, tbl[i].st, tbl[i].pa, tbl[i].su, tbl[i].go);
      check_all($sformatf("vec%0d", i), int'(tbl[i].et), tbl[i].el, tbl[i].es);
      // Frame strobes are spaced three clocks apart; gaps must show no tick.
      for (int g = 0; g < 2; g++) begin
        drive(0, 0, 0, 0, 0);
        check_all($sformatf("vec%0d.gap%0d", i, g), 0, tbl[i].el, tbl[i].es);
      end
    end

    // Randomized run against the reference model.
    reset = 1;
    #2;
    reset = 0;
    model_reset();
    @(posedge clk);
    #1;
    for (int c = 0; c < 3000; c++) begin
      logic fe, st, pa, su, go;
      fe = ($urandom_range(0, 2) == 0);
      st = ($urandom_range(0, 15) == 0);
      pa = ($urandom_range(0, 19) == 0);
      su = ($urandom_range(0, 9) == 0);
      go = ($urandom_range(0, 63) == 0);
      drive(fe, st, pa, su, go);
      model_step(fe, st, pa, su, go);
      check_all($sformatf("rnd%0d", c), m_tick, m_lvl, m_st);
    end

    // Mid-game async reset while tick is high, then a full period to the first tick.
    reset = 1;
    #2;
    reset = 0;
    drive(0, 1, 0, 0, 0);
    drive(0, 0, 0, 1, 0);
    drive(1, 0, 0, 0, 0);
    drive(1, 0, 0, 0, 0);
    drive(1, 0, 0, 0, 0);
    check_all("pre_reset", 1, 1, 1);
    #2;
    reset = 1;
    #1;
    check_all("async_reset", 0, 0, 0);
    @(posedge clk);
    #1;
    reset = 0;
    check_all("reset_held", 0, 0, 0);
    drive(0, 1, 0, 0, 0);
    check_all("restart", 0, 0, 1);
    for (int i = 1; i <= 4; i++) begin
      drive(1, 0, 0, 0, 0);
      check_all($sformatf("restart_fe%0d", i), (i == 4) ? 1 : 0, 0, 1);
    end
    drive(0, 0, 0, 0, 0);
    check_all("restart_tick_width", 0, 0, 1);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
